// File: rtl/alu_share_pkg.sv
// Shared types and constants for the two-requester ALU sharing controller.
package alu_share_pkg;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} share_state_t;

  // Bit positions inside the {Z,N,V,C} flag nibble.
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLAG_W = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational round-robin arbiter; on a tie the requester that was not
// granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt    = 2'b00;
    gnt_id = 1'b0;
    if (req == 2'b11) begin
      gnt_id = ~last_grant;
    end else begin
      gnt_id = req[1];
    end
    if (req != 2'b00) begin
      gnt = gnt_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between two requesters: arbitrate, register
// operands, drive the ALU for one cycle, then hold the captured response until taken.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int unsigned M     = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*M-1:0]      req_a,
  input  logic [2*M-1:0]      req_b,
  input  logic [2*OP_W-1:0]   req_op,
  output logic [1:0]          resp_valid,
  input  logic [1:0]          resp_ready,
  output logic [M-1:0]        resp_result,
  output logic [FLAG_W-1:0]   resp_flags,
  output logic [M-1:0]        alu_a,
  output logic [M-1:0]        alu_b,
  output logic [OP_W-1:0]     alu_ctrl,
  input  logic [M-1:0]        alu_result,
  input  logic [FLAG_W-1:0]   alu_flags,
  output logic [CNT_W-1:0]    ops_done
);

  share_state_t      state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic [M-1:0]      a_q, a_d;
  logic [M-1:0]      b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [1:0]        resp_valid_q, resp_valid_d;
  logic [M-1:0]      result_q, result_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [CNT_W-1:0]  ops_done_q, ops_done_d;

  logic [1:0] gnt;
  logic       gnt_id;

  rr_arb2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .gnt        (gnt),
    .gnt_id     (gnt_id)
  );

  // Gated by reset so every output reads zero while reset is held.
  assign req_ready = (!reset && state_q == S_IDLE) ? gnt : 2'b00;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    resp_valid_d = resp_valid_q;
    result_d     = result_q;
    flags_d      = flags_q;
    ops_done_d   = ops_done_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid != 2'b00) begin
          a_d     = gnt_id ? req_a[2*M-1:M] : req_a[M-1:0];
          b_d     = gnt_id ? req_b[2*M-1:M] : req_b[M-1:0];
          op_d    = gnt_id ? req_op[2*OP_W-1:OP_W] : req_op[OP_W-1:0];
          owner_d = gnt_id;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d     = alu_result;
        flags_d      = alu_flags;
        resp_valid_d = owner_q ? 2'b10 : 2'b01;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (resp_ready[owner_q]) begin
          resp_valid_d = 2'b00;
          last_grant_d = owner_q;
          ops_done_d   = ops_done_q + CNT_W'(1);
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      resp_valid_q <= 2'b00;
      result_q     <= '0;
      flags_q      <= '0;
      ops_done_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      resp_valid_q <= resp_valid_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
      ops_done_q   <= ops_done_d;
    end
  end

  // Operand registers feed the ALU directly, so it sees stable inputs from EXEC
  // through RESP.
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_ctrl    = op_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = result_q;
  assign resp_flags  = flags_q;
  assign ops_done    = ops_done_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: a wide-counter instance and a 2-bit-counter
// instance run in lockstep, each against a small add/sub ALU model.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic [7:0]  req_op;
  logic [1:0]  resp_ready;

  logic [1:0]  req_ready, resp_valid;
  logic [3:0]  resp_result, resp_flags, alu_a, alu_b, alu_ctrl, alu_result, alu_flags;
  logic [15:0] ops_done;

  logic [1:0]  w2_req_ready, w2_resp_valid;
  logic [3:0]  w2_resp_result, w2_resp_flags, w2_alu_a, w2_alu_b, w2_alu_ctrl;
  logic [3:0]  w2_alu_result, w2_alu_flags;
  logic [1:0]  w2_ops_done;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  // Returns {Z,N,V,C,result}; op 1 subtracts with C as borrow, anything else adds.
  function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] op);
    logic [4:0] s;
    logic [3:0] r;
    logic       v;
    if (op == 4'h1) begin
      s = {1'b0, a} - {1'b0, b};
      r = s[3:0];
      v = (a[3] != b[3]) && (r[3] != a[3]);
    end else begin
      s = {1'b0, a} + {1'b0, b};
      r = s[3:0];
      v = (a[3] == b[3]) && (r[3] != a[3]);
    end
    return {(r == 4'h0), r[3], v, s[4], r};
  endfunction

  assign {alu_flags, alu_result}       = alu_model(alu_a, alu_b, alu_ctrl);
  assign {w2_alu_flags, w2_alu_result} = alu_model(w2_alu_a, w2_alu_b, w2_alu_ctrl);

  alu_share_ctrl #(.M(4), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_flags  (resp_flags),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags),
    .ops_done    (ops_done)
  );

  alu_share_ctrl #(.M(4), .CNT_W(2)) dut_w2 (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (w2_req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .resp_valid  (w2_resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (w2_resp_result),
    .resp_flags  (w2_resp_flags),
    .alu_a       (w2_alu_a),
    .alu_b       (w2_alu_b),
    .alu_ctrl    (w2_alu_ctrl),
    .alu_result  (w2_alu_result),
    .alu_flags   (w2_alu_flags),
    .ops_done    (w2_ops_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, {30'd0, req_ready}, 32'd0);
    check({tag, "_resp_valid"}, {30'd0, resp_valid}, 32'd0);
    check({tag, "_resp_result"}, {28'd0, resp_result}, 32'd0);
    check({tag, "_resp_flags"}, {28'd0, resp_flags}, 32'd0);
    check({tag, "_alu_abc"}, {20'd0, alu_a, alu_b, alu_ctrl}, 32'd0);
    check({tag, "_ops_done"}, {16'd0, ops_done}, 32'd0);
  endtask

  // Runs one op whose request is already presented, with the owner's resp_ready high.
  task automatic serve(input logic [1:0] g, input logic [3:0] ea, input logic [3:0] eb,
                       input logic [3:0] eop, input logic [3:0] res, input logic [3:0] fl);
    check("grant", {30'd0, req_ready}, {30'd0, g});
    tick();
    check("exec_no_resp", {30'd0, resp_valid}, 32'd0);
    check("exec_alu_in", {20'd0, alu_a, alu_b, alu_ctrl}, {20'd0, ea, eb, eop});
    tick();
    check("resp_valid", {30'd0, resp_valid}, {30'd0, g});
    check("resp_result", {28'd0, resp_result}, {28'd0, res});
    check("resp_flags", {28'd0, resp_flags}, {28'd0, fl});
    tick();
    check("resp_cleared", {30'd0, resp_valid}, 32'd0);
    exp_cnt++;
    check("ops_done", {16'd0, ops_done}, exp_cnt);
    check("ops_done_w2", {30'd0, w2_ops_done}, exp_cnt % 4);
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = 2'b00;
    req_a      = 8'h00;
    req_b      = 8'h00;
    req_op     = 8'h00;
    resp_ready = 2'b11;
    tick();
    tick();
    check_all_zero("in_reset");
    reset = 1'b0;
    tick();
    check_all_zero("after_reset");

    // Tie from reset: r0 (7+9) first, then r1 (4-4), then r0 again.
    req_a     = {4'd4, 4'd7};
    req_b     = {4'd4, 4'd9};
    req_op    = {4'h1, 4'h0};
    req_valid = 2'b11;
    #1;
    serve(2'b01, 4'd7, 4'd9, 4'h0, 4'd0, 4'b1001);
    serve(2'b10, 4'd4, 4'd4, 4'h1, 4'd0, 4'b1000);
    serve(2'b01, 4'd7, 4'd9, 4'h0, 4'd0, 4'b1001);
    req_valid = 2'b00;

    // Single requester 0: 3+2.
    req_a     = {4'd0, 4'd3};
    req_b     = {4'd0, 4'd2};
    req_op    = {4'h0, 4'h0};
    req_valid = 2'b01;
    #1;
    serve(2'b01, 4'd3, 4'd2, 4'h0, 4'd5, 4'b0000);
    req_valid = 2'b00;

    // Owner r1 stalls its response while the non-owner's resp_ready is high.
    req_a      = {4'd5, 4'd0};
    req_b      = {4'd1, 4'd0};
    req_op     = {4'h1, 4'h0};
    req_valid  = 2'b10;
    resp_ready = 2'b01;
    #1;
    check("stall_grant", {30'd0, req_ready}, 32'd2);
    tick();
    req_valid = 2'b11;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_resp_valid", {30'd0, resp_valid}, 32'd2);
      check("stall_result", {28'd0, resp_result}, 32'd4);
      check("stall_flags", {28'd0, resp_flags}, 32'd0);
      check("stall_req_ready", {30'd0, req_ready}, 32'd0);
      tick();
    end
    req_valid  = 2'b00;
    resp_ready = 2'b10;
    check("stall_still_valid", {30'd0, resp_valid}, 32'd2);
    tick();
    check("stall_released", {30'd0, resp_valid}, 32'd0);
    exp_cnt++;
    check("stall_ops_done", {16'd0, ops_done}, exp_cnt);
    check("stall_ops_done_w2", {30'd0, w2_ops_done}, exp_cnt % 4);
    resp_ready = 2'b11;

    // Mid-run reset while a response is pending.
    req_a     = {4'd0, 4'd6};
    req_b     = {4'd0, 4'd3};
    req_op    = {4'h0, 4'h1};
    req_valid = 2'b01;
    resp_ready = 2'b00;
    tick();
    tick();
    check("pre_reset_valid", {30'd0, resp_valid}, 32'd1);
    check("pre_reset_result", {28'd0, resp_result}, 32'd3);
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    check("async_reset_w2", {30'd0, w2_ops_done}, 32'd0);
    tick();
    req_valid  = 2'b00;
    resp_ready = 2'b11;
    reset      = 1'b0;
    exp_cnt    = 0;
    tick();
    check_all_zero("post_reset");

    // Reset while in EXEC: that op must never respond.
    req_valid = 2'b01;
    #1;
    check("exec_rst_grant", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("exec_rst_no_resp", {30'd0, resp_valid}, 32'd0);
    end
    check("exec_rst_ops_done", {16'd0, ops_done}, 32'd0);

    // Tie after reset goes back to requester 0.
    req_a     = {4'd1, 4'd2};
    req_b     = {4'd1, 4'd2};
    req_op    = {4'h0, 4'h0};
    req_valid = 2'b11;
    #1;
    serve(2'b01, 4'd2, 4'd2, 4'h0, 4'd4, 4'b0000);
    req_valid = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
